// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//
// Sequencer for the MEM stage of the pipelined MIPS core. It watches the
// memory-control outputs of the EX/MEM register and runs each load/store
// against a multi-cycle data memory over a req/ack handshake. While an
// access is outstanding it freezes the upstream pipeline and bubbles
// MEM/WB. A watchdog aborts any access not acknowledged within TIMEOUT
// WAIT cycles, so the core cannot deadlock.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous active-low reset
//   mem_read_i   MemRead from EX/MEM
//   mem_write_i  MemWrite from EX/MEM
//   addr_i       byte address (ALU result) from EX/MEM
//   wdata_i      store data from EX/MEM
//   dm_req_o     request to data memory (high in WAIT)
//   dm_we_o      1 = write, 0 = read, valid while dm_req_o
//   dm_addr_o    latched address, valid while dm_req_o
//   dm_wdata_o   latched write data, valid while dm_req_o
//   dm_ack_i     single-cycle completion pulse from data memory
//   dm_rdata_i   read data, valid with dm_ack_i
//   rdata_o      registered load result for MEM/WB
//   stall_o      freezes PC, IF/ID, ID/EX, EX/MEM
//   bubble_o     forces MEM/WB control to NOP
//   err_o        sticky timeout flag, cleared only by reset

module mem_stage_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        dm_req_o,
   output logic        dm_we_o,
   output logic [31:0] dm_addr_o,
   output logic [31:0] dm_wdata_o,
   input  logic        dm_ack_i,
   input  logic [31:0] dm_rdata_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        bubble_o,
   output logic        err_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             acc;

   assign acc = mem_read_i | mem_write_i;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; DONE never samples EX/MEM so the completing
   // instruction cannot retrigger an access.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (acc) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (dm_ack_i || (cnt == CNT_MAX)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output decode. Stall is gated by rst so the pipeline is never held
   // while reset is asserted, even if the FSM is still in WAIT.
   always_comb begin
      stall_o  = 1'b0;
      dm_req_o = 1'b0;
      case (state)
         IDLE: stall_o = acc & rst;
         WAIT: begin
            stall_o  = rst;
            dm_req_o = 1'b1;
         end
         default: begin
            stall_o  = 1'b0;
            dm_req_o = 1'b0;
         end
      endcase
      bubble_o = stall_o;
   end

   // Request latches, watchdog counter and result/error registers.
   // Write wins when both MemRead and MemWrite are set.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dm_addr_o  <= '0;
         dm_wdata_o <= '0;
         dm_we_o    <= 1'b0;
         cnt        <= '0;
         rdata_o    <= '0;
         err_o      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (acc) begin
                  dm_addr_o  <= addr_i;
                  dm_wdata_o <= wdata_i;
                  dm_we_o    <= mem_write_i;
                  cnt        <= '0;
               end
            end
            WAIT: begin
               // Ack takes precedence over a timeout in the same cycle.
               if (dm_ack_i) begin
                  if (!dm_we_o) begin
                     rdata_o <= dm_rdata_i;
                  end
               end else if (cnt == CNT_MAX) begin
                  err_o   <= 1'b1;
                  rdata_o <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the MEM stage of the pipelined MIPS core. It watches the memory-control outputs of the EX/MEM pipeline register and drives a multi-cycle data memory over a req/ack handshake. While an access is outstanding, it freezes the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) and inserts bubbles into MEM/WB. A watchdog aborts accesses the memory never acknowledges, so the core cannot deadlock.

## Interface
- TIMEOUT, 15: maximum WAIT cycles without ack before abort (≥1).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on posedge).
- mem_read_i  in  1  MemRead from EX/MEM output.
- mem_write_i  in  1  MemWrite from EX/MEM output.
- addr_i  in  32  ALU result from EX/MEM, used as the byte address.
- wdata_i  in  32  WriteData from EX/MEM.
- dm_req_o  out  1  access request to the data memory.
- dm_we_o  out  1  1 = write, 0 = read; valid while dm_req_o.
- dm_addr_o  out  32  latched address; valid while dm_req_o.
- dm_wdata_o  out  32  latched write data; valid while dm_req_o.
- dm_ack_i  in  1  memory completion; single-cycle pulse.
- dm_rdata_i  in  32  read data; valid in the cycle dm_ack_i=1.
- rdata_o  out  32  load result presented to MEM/WB.
- stall_o  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
- bubble_o  out  1  forces MEM/WB control to NOP (RegWrite=0, MemToReg=0).
- err_o  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, WAIT, DONE. State encoding is free.
- IDLE:
  - acc = mem_read_i | mem_write_i.
  - If acc: latch addr_i → dm_addr_o and wdata_i → dm_wdata_o. Latch dm_we_o = mem_write_i (write has priority if both are set; no error raised). Clear cnt. Go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - dm_req_o=1. dm_addr_o, dm_we_o and dm_wdata_o are held stable.
  - dm_ack_i=1: if it is a read, rdata_o ← dm_rdata_i; a write leaves rdata_o unchanged. Go to DONE.
  - dm_ack_i=0 and cnt==TIMEOUT-1: err_o ← 1, rdata_o ← 0. Go to DONE (abort).
  - Otherwise cnt ← cnt+1.
  - If ack arrives in the timeout cycle, ack wins: err_o stays unchanged and rdata_o takes dm_rdata_i.
- DONE:
  - Stall is released for exactly one cycle, so EX/MEM advances and MEM/WB captures the real instruction with rdata_o.
  - Always returns to IDLE. EX/MEM inputs are not sampled in DONE, so the completing instruction cannot retrigger.
- Output decode:
  - stall_o = (IDLE & acc & rst) | WAIT.
  - bubble_o = stall_o.
  - dm_req_o = WAIT.
- dm_ack_i outside WAIT is ignored.
- cnt width is clog2(TIMEOUT+1). cnt never exceeds TIMEOUT-1.
- err_o is cleared only by reset.
- Non-memory instructions pass through with zero added cycles: stall_o=0 and bubble_o=0 in IDLE when acc=0.

## Timing
- Reset (rst==0 at posedge), applicable in any state including mid-access:
  - state=IDLE, cnt=0, rdata_o=0, err_o=0.
  - dm_addr_o=0, dm_wdata_o=0, dm_we_o=0.
  - dm_req_o=0 from the next cycle.
  - While rst==0, stall_o and bubble_o are 0.
- An access whose ack arrives in the Nth WAIT cycle (N ≤ TIMEOUT):
  - stall_o high for N+1 cycles (detect cycle + N WAIT cycles).
  - DONE for 1 cycle; total occupancy N+2 cycles.
- Minimum occupancy is 3 cycles (ack in the first WAIT cycle).
- Abort: stall_o high for TIMEOUT+1 cycles, then DONE; dm_req_o is low from DONE onward.
- dm_req_o rises the cycle after detection and falls the cycle after ack.
- rdata_o is registered: it is valid from the DONE cycle and holds until the next read completion or reset.
- Back-to-back memory instructions: DONE → IDLE (new instruction detected, stall_o=1) → WAIT. There is no gap cycle beyond DONE.

## Test plan
- Load, ack in the 3rd WAIT cycle with dm_rdata_i=0xDEADBEEF, addr_i=0x40:
  - dm_req_o high for 3 cycles with dm_addr_o=0x40 and dm_we_o=0.
  - stall_o and bubble_o high for 4 cycles.
  - rdata_o=0xDEADBEEF in DONE.
  - err_o=0.
- Store, wdata_i=0x12345678, ack in the 1st WAIT cycle:
  - dm_we_o=1 and dm_wdata_o=0x12345678 during the request.
  - stall_o high for 2 cycles; rdata_o unchanged.
- ALU-only instruction stream (mem_read_i=mem_write_i=0) for 10 cycles: stall_o, bubble_o and dm_req_o stay 0 throughout.
- No ack, TIMEOUT=15:
  - dm_req_o high for exactly 15 cycles.
  - err_o rises after the 15th WAIT cycle and stays high.
  - rdata_o=0; FSM returns to IDLE.
- Ack on the 15th WAIT cycle (rdata 0xA5A5A5A5): err_o=0, rdata_o=0xA5A5A5A5.
- rst=0 asserted in the 2nd WAIT cycle of a load:
  - Next cycle: dm_req_o=0 and all outputs at reset values.
  - A late dm_ack_i is ignored.
  - A load issued after rst=1 completes normally.
- mem_read_i=mem_write_i=1: the access is treated as a write (dm_we_o=1) and err_o stays 0.
